// File: rtl/divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency: 33 cycles from accepted startE to ready; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: none; startE is ignored while busy, and div_use stalls the pipeline during the divide.
module divider_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result_divide,
    output logic             ready,
    output logic             div_use
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   quo, rem, dvsr;
    logic               is_rem, neg_quo, neg_rem;

    logic               is_signed, op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic               div_zero, sgn_ovf, special;
    logic [WIDTH-1:0]   special_res;

    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   quo_step, rem_step, quo_fix, rem_fix, final_res;
    logic               last_step;

    // Request decode: operand magnitudes and the two results that skip iteration
    always_comb begin
        is_signed   = ~div_opcode[0];
        op1_neg     = is_signed & operand1[WIDTH-1];
        op2_neg     = is_signed & operand2[WIDTH-1];
        op1_mag     = op1_neg ? -operand1 : operand1;
        op2_mag     = op2_neg ? -operand2 : operand2;
        div_zero    = (operand2 == '0);
        sgn_ovf     = is_signed && (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (operand2 == '1);
        special     = div_zero | sgn_ovf;
        if (div_zero)
            special_res = div_opcode[1] ? operand1 : '1;
        else
            special_res = div_opcode[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // One restoring step plus the sign fixup applied on the final step
    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvsr};
        quo_step  = {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem_step  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_fix   = neg_quo ? -quo_step : quo_step;
        rem_fix   = neg_rem ? -rem_step : rem_step;
        final_res = is_rem ? rem_fix : quo_fix;
        last_step = (counter == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, ready pulse and stall request; ready and div_use are exclusive by state
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        div_use   = 1'b0;
        case (state)
            IDLE: begin
                if (startE) begin
                    div_use   = ~special;
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                div_use = 1'b1;
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in CALC, register result on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter       <= '0;
            quo           <= '0;
            rem           <= '0;
            dvsr          <= '0;
            is_rem        <= 1'b0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
            result_divide <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startE) begin
                        is_rem  <= div_opcode[1];
                        neg_quo <= op1_neg ^ op2_neg;
                        neg_rem <= op1_neg;
                        quo     <= op1_mag;
                        rem     <= '0;
                        dvsr    <= op2_mag;
                        counter <= '0;
                        if (special)
                            result_divide <= special_res;
                    end
                end
                CALC: begin
                    quo     <= quo_step;
                    rem     <= rem_step;
                    counter <= counter + CNT_W'(1);
                    if (last_step)
                        result_divide <= final_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed RV32M cases plus randomized operations.
// Latency: checks 33-cycle normal and 1-cycle special-case completion against a cycle-level model.
// Backpressure: exercises startE while busy and asynchronous reset during a divide.
module tb_divider_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic [1:0]  div_opcode;
    logic [31:0] operand1, operand2;
    logic [31:0] result_divide;
    logic        ready, div_use;

    int chk = 0;
    int err = 0;

    divider_iterative #(.WIDTH(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .startE       (startE),
        .div_opcode   (div_opcode),
        .operand1     (operand1),
        .operand2     (operand2),
        .result_divide(result_divide),
        .ready        (ready),
        .div_use      (div_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M reference semantics using plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b10:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            2'b01:   return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Cycle-level model: m_cnt counts remaining iteration edges, m_done marks the ready cycle
    int          m_cnt;
    bit          m_done;
    logic [31:0] m_res, m_pend;
    bit          cmp_en = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_res  = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else if (startE) begin
            m_pend = ref_div(div_opcode, operand1, operand2);
            if (is_special(div_opcode, operand1, operand2)) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end else begin
                m_cnt = 32;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_result", result_divide, m_res);
            check("cyc_ready", {31'h0, ready}, {31'h0, m_done});
            check("cyc_div_use", {31'h0, div_use},
                  {31'h0, (m_cnt > 0) || (!m_done && m_cnt == 0 && startE &&
                                          !is_special(div_opcode, operand1, operand2))});
            check("cyc_exclusive", {31'h0, ready & div_use}, 32'h0);
        end
    end

    // Issue one request, optionally re-pulse startE while busy, and check result, latency and stall length
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int reissue_at);
        int lat = 0;
        int use_cnt = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startE     = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == reissue_at) begin
                startE = 1'b1; div_opcode = 2'b00; operand1 = 32'd50; operand2 = 32'd5;
            end else begin
                startE = 1'b0; div_opcode = 2'($urandom); operand1 = $urandom; operand2 = $urandom;
            end
            @(negedge clk);
            if (div_use) use_cnt++;
            if (ready) got = 1'b1;
        end
        check({name, "_ready_seen"}, {31'h0, got}, 32'h1);
        check({name, "_result"}, result_divide, exp_res);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_div_use_cycles"}, use_cnt, (exp_lat == 1) ? 0 : 32);
        @(posedge clk);
        #1;
        check({name, "_ready_one_cycle"}, {31'h0, ready}, 32'h0);
    endtask

    function automatic logic [31:0] rand_val(input bit divisor);
        case ($urandom_range(0, 7))
            0:       return divisor ? 32'h0 : 32'h8000_0000;
            1:       return divisor ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            2, 3:    return $urandom_range(0, 300);
            4:       return -$urandom_range(1, 300);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          seen;

        rst = 1'b0; startE = 1'b0; div_opcode = 2'b00; operand1 = 32'h0; operand2 = 32'h0;

        // Pin the reference model to hand-computed values
        check("model_div_100_7", ref_div(2'b00, 32'd100, 32'd7), 32'h0000_000E);
        check("model_rem_m20_3", ref_div(2'b10, -32'd20, 32'd3), 32'hFFFF_FFFE);
        check("model_div_m20_3", ref_div(2'b00, -32'd20, 32'd3), 32'hFFFF_FFFA);
        check("model_divu_zero", ref_div(2'b01, 32'h1234, 32'd0), 32'hFFFF_FFFF);
        check("model_div_ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        #2;
        check("reset_result", result_divide, 32'h0);
        check("reset_ready", {31'h0, ready}, 32'h0);
        check("reset_div_use", {31'h0, div_use}, 32'h0);
        #20;
        rst    = 1'b1;
        cmp_en = 1'b1;

        run_op("div_100_7",   2'b00, 32'd100, 32'd7, 32'h0000_000E, 33, -1);
        run_op("rem_100_7",   2'b10, 32'd100, 32'd7, 32'h0000_0002, 33, -1);
        run_op("div_m20_3",   2'b00, -32'd20, 32'd3, 32'hFFFF_FFFA, 33, -1);
        run_op("rem_m20_3",   2'b10, -32'd20, 32'd3, 32'hFFFF_FFFE, 33, -1);
        run_op("divu_max_2",  2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, -1);
        run_op("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, -1);
        run_op("div_zero",    2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, -1);
        run_op("remu_zero",   2'b11, 32'h1234, 32'd0, 32'h0000_1234, 1, -1);
        run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
        run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, -1);
        run_op("reissue",     2'b00, 32'd100, 32'd7, 32'h0000_000E, 33, 10);
        run_op("fresh_50_5",  2'b00, 32'd50, 32'd5, 32'h0000_000A, 33, -1);

        // Asynchronous reset in the middle of a divide
        @(posedge clk);
        #1;
        div_opcode = 2'b00; operand1 = 32'd100; operand2 = 32'd7; startE = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_result", result_divide, 32'h0);
        check("midreset_ready", {31'h0, ready}, 32'h0);
        check("midreset_div_use", {31'h0, div_use}, 32'h0);
        #14;
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("midreset_no_ready", {31'h0, seen}, 32'h0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'h0000_0003, 33, -1);

        // Randomized operations across all opcodes and corner operands
        for (int n = 0; n < 250; n++) begin
            op = 2'($urandom);
            a  = rand_val(1'b0);
            b  = rand_val(1'b1);
            run_op("rand", op, a, b, ref_div(op, a, b), is_special(op, a, b) ? 1 : 33, -1);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
